// File: rtl/uart_spi_bridge.sv
// Bridges UART and SPI. Two received bytes form one 16-bit SPI command word, high byte first.
// The 16-bit SPI response goes back out as two UART bytes, high byte first.
module uart_spi_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    input  logic        uart_tx_busy,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_start,
    output logic [15:0] spi_tx_data,
    output logic        spi_start,
    input  logic [15:0] spi_rx_data,
    input  logic        spi_done,
    output logic        bridge_busy,
    output logic        timeout_err,
    output logic        overrun_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE,
        GOT_HI,
        SPI_REQ,
        SPI_WAIT,
        TX_HI,
        TX_HI_WAIT,
        TX_LO,
        TX_LO_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hi_byte_q, hi_byte_d;
    logic [15:0] resp_q, resp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        guard_q, guard_d;

    logic [7:0]  tx_data_d;
    logic        tx_start_d;
    logic [15:0] spi_data_d;
    logic        spi_start_d;
    logic        busy_d;
    logic        timeout_d;
    logic        overrun_d;

    // State, holding registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            hi_byte_q     <= '0;
            resp_q        <= '0;
            cnt_q         <= '0;
            guard_q       <= 1'b0;
            uart_tx_data  <= '0;
            uart_tx_start <= 1'b0;
            spi_tx_data   <= '0;
            spi_start     <= 1'b0;
            bridge_busy   <= 1'b0;
            timeout_err   <= 1'b0;
            overrun_err   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hi_byte_q     <= hi_byte_d;
            resp_q        <= resp_d;
            cnt_q         <= cnt_d;
            guard_q       <= guard_d;
            uart_tx_data  <= tx_data_d;
            uart_tx_start <= tx_start_d;
            spi_tx_data   <= spi_data_d;
            spi_start     <= spi_start_d;
            bridge_busy   <= busy_d;
            timeout_err   <= timeout_d;
            overrun_err   <= overrun_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        hi_byte_d   = hi_byte_q;
        resp_d      = resp_q;
        cnt_d       = cnt_q;
        guard_d     = 1'b0;
        tx_data_d   = uart_tx_data;
        tx_start_d  = 1'b0;
        spi_data_d  = spi_tx_data;
        spi_start_d = 1'b0;
        timeout_d   = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (uart_rx_valid) begin
                    hi_byte_d = uart_rx_data;
                    cnt_d     = '0;
                    state_d   = GOT_HI;
                end
            end
            GOT_HI: begin
                // A byte arriving in the expiry cycle takes priority over the timeout
                if (uart_rx_valid) begin
                    spi_data_d = {hi_byte_q, uart_rx_data};
                    state_d    = SPI_REQ;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SPI_REQ: begin
                spi_start_d = 1'b1;
                state_d     = SPI_WAIT;
            end
            SPI_WAIT: begin
                if (spi_done) begin
                    resp_d  = spi_rx_data;
                    state_d = TX_HI;
                end
            end
            TX_HI: begin
                if (!uart_tx_busy) begin
                    tx_data_d  = resp_q[15:8];
                    tx_start_d = 1'b1;
                    guard_d    = 1'b1;
                    state_d    = TX_HI_WAIT;
                end
            end
            TX_HI_WAIT: begin
                // Transmitter may not have raised busy yet in the guard cycle
                if (!guard_q && !uart_tx_busy) begin
                    state_d = TX_LO;
                end
            end
            TX_LO: begin
                if (!uart_tx_busy) begin
                    tx_data_d  = resp_q[7:0];
                    tx_start_d = 1'b1;
                    guard_d    = 1'b1;
                    state_d    = TX_LO_WAIT;
                end
            end
            TX_LO_WAIT: begin
                if (!guard_q && !uart_tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        overrun_d = uart_rx_valid && !(state_q inside {IDLE, GOT_HI});
        busy_d    = !(state_d inside {IDLE, GOT_HI});
    end

endmodule

// File: tb/tb_uart_spi_bridge.sv
// Self-checking bench for uart_spi_bridge: directed scenarios plus randomized commands
// against a transaction-level expectation of SPI words and UART response bytes.
module tb_uart_spi_bridge;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_tx_busy;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_start;
    logic [15:0] spi_tx_data;
    logic        spi_start;
    logic [15:0] spi_rx_data;
    logic        spi_done;
    logic        bridge_busy;
    logic        timeout_err;
    logic        overrun_err;

    logic force_busy = 1'b0;
    logic model_busy = 1'b0;
    assign uart_tx_busy = force_busy | model_busy;

    int tests = 0;
    int fails = 0;

    logic [15:0] spi_q[$];
    logic [7:0]  tx_q[$];
    int          tx_cyc_q[$];
    int          cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    int          to_cnt = 0;
    int          ov_cnt = 0;
    int          start_dbl = 0;
    logic        prev_start = 1'b0;
    logic [15:0] spi_resp = 16'h0;
    int          spi_lat = 3;

    uart_spi_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_tx_busy  (uart_tx_busy),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_start (uart_tx_start),
        .spi_tx_data   (spi_tx_data),
        .spi_start     (spi_start),
        .spi_rx_data   (spi_rx_data),
        .spi_done      (spi_done),
        .bridge_busy   (bridge_busy),
        .timeout_err   (timeout_err),
        .overrun_err   (overrun_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Transaction monitor, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (spi_start) begin
            spi_q.push_back(spi_tx_data);
            if (prev_start) start_dbl++;
        end
        prev_start = spi_start;
        if (uart_tx_start) begin
            tx_q.push_back(uart_tx_data);
            tx_cyc_q.push_back(cyc);
        end
        if (spi_done) begin
            done_cyc = cyc;
            done_cnt++;
        end
        if (timeout_err) to_cnt++;
        if (overrun_err) ov_cnt++;
    end

    // SPI slave model: answers each request after spi_lat cycles
    initial begin
        spi_done    = 1'b0;
        spi_rx_data = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (spi_start) begin
                repeat (spi_lat) @(negedge clk);
                spi_rx_data = spi_resp;
                spi_done    = 1'b1;
                @(negedge clk);
                spi_done    = 1'b0;
                spi_rx_data = 16'($urandom);
            end
        end
    end

    // UART transmitter model: busy for a few cycles after each start
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (uart_tx_start) begin
                model_busy = 1'b1;
                repeat ($urandom_range(2, 6)) @(posedge clk);
                #1 model_busy = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        uart_rx_data  = b;
        uart_rx_valid = 1'b1;
        @(negedge clk);
        uart_rx_valid = 1'b0;
        uart_rx_data  = 8'($urandom);
    endtask

    task automatic wait_idle(input int t_target, input string tag);
        int n;
        n = 0;
        while ((tx_q.size() < t_target || bridge_busy !== 1'b0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, " completes"}, 32'(n < 400), 32'd1);
    endtask

    function automatic logic [15:0] spi_at(input int idx);
        return (spi_q.size() > idx) ? spi_q[idx] : 16'hxxxx;
    endfunction

    function automatic logic [7:0] tx_at(input int idx);
        return (tx_q.size() > idx) ? tx_q[idx] : 8'hxx;
    endfunction

    task automatic run_cmd(input logic [7:0] b1, input logic [7:0] b2, input logic [15:0] resp,
                           input int gap, input string tag);
        int s0;
        int t0;
        s0 = spi_q.size();
        t0 = tx_q.size();
        spi_resp = resp;
        send_byte(b1);
        repeat (gap) @(negedge clk);
        send_byte(b2);
        wait_idle(t0 + 2, tag);
        check({tag, " spi count"}, 32'(spi_q.size()), 32'(s0 + 1));
        check({tag, " spi word"}, 32'(spi_at(s0)), 32'({b1, b2}));
        check({tag, " tx hi"}, 32'(tx_at(t0)), 32'(resp[15:8]));
        check({tag, " tx lo"}, 32'(tx_at(t0 + 1)), 32'(resp[7:0]));
    endtask

    initial begin
        int s0;
        int t0;
        int k;
        int tc;
        int oc;
        int d0;

        rst_n         = 1'b0;
        uart_rx_valid = 1'b0;
        uart_rx_data  = 8'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset outputs", 32'({uart_tx_data, uart_tx_start, spi_tx_data, spi_start,
                                     bridge_busy, timeout_err, overrun_err}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset busy", 32'(bridge_busy), 32'd0);
        check("post-reset spi_start", 32'(spi_start), 32'd0);

        // Nominal command with cycle-level timing checks
        spi_lat  = 3;
        spi_resp = 16'h1234;
        s0 = spi_q.size();
        t0 = tx_q.size();
        send_byte(8'hA5);
        repeat (9) @(negedge clk);
        send_byte(8'h5A);
        check("nom busy after accept", 32'(bridge_busy), 32'd1);
        check("nom spi_tx_data early", 32'(spi_tx_data), 32'h0000A55A);
        check("nom spi_start not yet", 32'(spi_start), 32'd0);
        @(negedge clk);
        check("nom spi_start pulse", 32'(spi_start), 32'd1);
        @(negedge clk);
        check("nom spi_start single", 32'(spi_start), 32'd0);
        check("nom spi_tx_data held", 32'(spi_tx_data), 32'h0000A55A);
        wait_idle(t0 + 2, "nom");
        check("nom spi word", 32'(spi_at(s0)), 32'h0000A55A);
        check("nom tx hi", 32'(tx_at(t0)), 32'h12);
        check("nom tx lo", 32'(tx_at(t0 + 1)), 32'h34);
        check("nom first tx latency", 32'(tx_cyc_q[t0] - done_cyc), 32'd1);
        check("nom tx spacing", 32'(tx_cyc_q[t0 + 1] - tx_cyc_q[t0] >= 3), 32'd1);

        // Randomized commands against the transaction expectation
        for (int i = 0; i < 6; i++) begin
            spi_lat = $urandom_range(1, 6);
            run_cmd(8'($urandom), 8'($urandom), 16'($urandom), $urandom_range(0, 12), "rand");
        end

        // Timeout: lone high byte then silence
        spi_lat = 3;
        s0 = spi_q.size();
        tc = to_cnt;
        send_byte(8'h77);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (timeout_err !== 1'b1 && k < 40);
        check("timeout latency", 32'(k), 32'd16);
        @(negedge clk);
        check("timeout single pulse", 32'(timeout_err), 32'd0);
        check("timeout no spi", 32'(spi_q.size()), 32'(s0));
        check("timeout busy low", 32'(bridge_busy), 32'd0);
        run_cmd(8'h01, 8'h02, 16'hC0DE, 2, "after timeout");
        check("timeout count", 32'(to_cnt), 32'(tc + 1));

        // Race: second byte in the expiry cycle
        tc = to_cnt;
        s0 = spi_q.size();
        spi_resp = 16'h5AA5;
        send_byte(8'h4D);
        repeat (14) @(negedge clk);
        send_byte(8'hD4);
        wait_idle(tx_q.size() + 2, "race");
        check("race spi word", 32'(spi_at(s0)), 32'h00004DD4);
        check("race no timeout", 32'(to_cnt), 32'(tc));

        // Overrun during SPI_WAIT
        spi_lat = 10;
        spi_resp = 16'h1234;
        s0 = spi_q.size();
        t0 = tx_q.size();
        oc = ov_cnt;
        send_byte(8'h3C);
        send_byte(8'hC3);
        repeat (3) @(negedge clk);
        send_byte(8'hFF);
        check("overrun pulse", 32'(overrun_err), 32'd1);
        @(negedge clk);
        check("overrun single", 32'(overrun_err), 32'd0);
        wait_idle(t0 + 2, "overrun");
        check("overrun count", 32'(ov_cnt), 32'(oc + 1));
        check("overrun spi count", 32'(spi_q.size()), 32'(s0 + 1));
        check("overrun tx hi", 32'(tx_at(t0)), 32'h12);
        check("overrun tx lo", 32'(tx_at(t0 + 1)), 32'h34);

        // Backpressure: busy held 40 cycles after spi_done
        spi_lat = 2;
        spi_resp = 16'h9876;
        t0 = tx_q.size();
        d0 = done_cnt;
        force_busy = 1'b1;
        send_byte(8'h11);
        send_byte(8'h22);
        k = 0;
        while (done_cnt == d0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("bp spi_done seen", 32'(k < 100), 32'd1);
        repeat (40) @(negedge clk);
        check("bp no tx while busy", 32'(tx_q.size()), 32'(t0));
        force_busy = 1'b0;
        @(negedge clk);
        check("bp tx_start after release", 32'(uart_tx_start), 32'd1);
        check("bp tx data", 32'(uart_tx_data), 32'h98);
        wait_idle(t0 + 2, "bp");
        check("bp tx lo", 32'(tx_at(t0 + 1)), 32'h76);

        // Reset during TX_HI_WAIT
        spi_lat = 2;
        spi_resp = 16'hAAAA;
        t0 = tx_q.size();
        send_byte(8'hC3);
        send_byte(8'h3C);
        k = 0;
        while (tx_q.size() < t0 + 1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("rst first byte seen", 32'(k < 200), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst async outputs", 32'({uart_tx_data, uart_tx_start, spi_tx_data, spi_start,
                                        bridge_busy, timeout_err, overrun_err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        run_cmd(8'hBE, 8'hEF, 16'($urandom), 3, "after reset");

        check("spi_start never wide", 32'(start_dbl), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
